// File: rtl/process_data_mul_pipe.sv
// process_data_mul_pipe
// Pipelined, valid/ready flow-controlled integer multiplier.
// Stage 1 captures the operands and the later stages carry the product.
// With NUM_STAGE=1 the product is formed from the inputs and registered once.
// Each stage can stall on its own, so bubbles collapse and the pipe fills
// while the consumer stalls.
// Optional build macro PROCESS_DATA_MUL_SAT_EN: the final stage clamps an
// out-of-range product instead of wrapping it.

module process_data_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 34,
  parameter int dout_WIDTH = 65,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Both operands are extended to this width, so every product is exact.
  localparam int PW = din0_WIDTH + din1_WIDTH + 1;
  // One bit wider than either the product or dout, so range checks never
  // need an empty slice.
  localparam int EW = ((dout_WIDTH > PW) ? dout_WIDTH : PW) + 1;
`ifdef PROCESS_DATA_MUL_SAT_EN
  localparam bit RES_SIGNED = (SIGNED0 != 0) || (SIGNED1 != 0);
`endif

  // Elaboration-time parameter checks.
  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("process_data_mul_pipe: NUM_STAGE must be 1..8");
  end
  if (din0_WIDTH < 1 || din0_WIDTH > 64 || din1_WIDTH < 1 || din1_WIDTH > 64) begin : g_bad_din
    $error("process_data_mul_pipe: operand widths must be 1..64");
  end
  if (dout_WIDTH < 1 || dout_WIDTH > 128) begin : g_bad_dout
    $error("process_data_mul_pipe: dout_WIDTH must be 1..128");
  end
  if (ID < 0) begin : g_bad_id
    $error("process_data_mul_pipe: ID must be non-negative");
  end

  // Extends operand A to PW bits. The sign is extended only when A is signed.
  function automatic logic signed [PW-1:0] ext_a(input logic [din0_WIDTH-1:0] x);
    logic s;
    s = (SIGNED0 != 0) & x[din0_WIDTH-1];
    return $signed({{(PW-din0_WIDTH){s}}, x});
  endfunction

  // Extends operand B to PW bits. The sign is extended only when B is signed.
  function automatic logic signed [PW-1:0] ext_b(input logic [din1_WIDTH-1:0] x);
    logic s;
    s = (SIGNED1 != 0) & x[din1_WIDTH-1];
    return $signed({{(PW-din1_WIDTH){s}}, x});
  endfunction

  // Maps the exact product onto dout. By default the product wraps to the
  // low dout_WIDTH bits. With the macro defined it clamps to the nearest
  // value that dout can represent.
  function automatic logic [dout_WIDTH-1:0] fmt_result(input logic signed [PW-1:0] p);
    logic signed [EW-1:0] e;
`ifdef PROCESS_DATA_MUL_SAT_EN
    logic signed [EW-1:0] hi;
    logic [dout_WIDTH-1:0] lim;
    logic                  fits;
`endif
    e = {{(EW-PW){p[PW-1]}}, p};
`ifdef PROCESS_DATA_MUL_SAT_EN
    if (RES_SIGNED) begin
      // The value fits when every bit from the dout sign bit upward matches.
      hi   = e >>> (dout_WIDTH - 1);
      fits = (hi == '0) || (hi == '1);
      if (e[EW-1]) begin
        lim = '0;
        lim[dout_WIDTH-1] = 1'b1;
      end else begin
        lim = '1;
        lim[dout_WIDTH-1] = 1'b0;
      end
    end else begin
      // An unsigned product is never negative, so only overflow is possible.
      hi   = e >>> dout_WIDTH;
      fits = (hi == '0);
      lim  = '1;
    end
    return fits ? e[dout_WIDTH-1:0] : lim;
`else
    return e[dout_WIDTH-1:0];
`endif
  endfunction

  logic [NUM_STAGE:1]    r_vld;      // valid bit of each stage
  logic [NUM_STAGE:1]    w_adv;      // stage may take a new value this cycle
  logic [NUM_STAGE:1]    w_vld_in;   // valid bit presented to each stage
  logic [NUM_STAGE:1]    w_ld;       // stage captures new data this cycle
  logic signed [PW-1:0]  w_fin_src;  // product entering the final stage
  logic [dout_WIDTH-1:0] r_dout;

  // A stage advances when it is empty or when the stage after it advances.
  // The chain starts at out_ready, so in_ready depends combinationally on it.
  always_comb begin
    w_adv = '0;
    w_adv[NUM_STAGE] = !r_vld[NUM_STAGE] | out_ready;
    for (int k = NUM_STAGE - 1; k >= 1; k--) begin
      w_adv[k] = !r_vld[k] | w_adv[k+1];
    end
  end

  // Selects the upstream valid bit for each stage: stage 1 sees in_valid.
  always_comb begin
    w_vld_in = '0;
    w_vld_in[1] = in_valid;
    for (int k = 2; k <= NUM_STAGE; k++) begin
      w_vld_in[k] = r_vld[k-1];
    end
  end

  // Data moves only with a real item, so a bubble never overwrites a held value.
  assign w_ld = w_adv & w_vld_in;

  // Valid bits follow their stage. A stalled stage keeps its valid bit.
  // Operand data never feeds these bits, so X operands cannot reach them.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_vld <= '0;
    else           r_vld <= (w_adv & w_vld_in) | (~w_adv & r_vld);
  end

  if (NUM_STAGE == 1) begin : g_s1
    // ---- single stage: multiply straight from the ports ----
    assign w_fin_src = ext_a(din0) * ext_b(din1);
  end else begin : g_sn
    logic [din0_WIDTH-1:0] r_opa_p1;
    logic [din1_WIDTH-1:0] r_opb_p1;
    logic signed [PW-1:0]  w_mul;

    // ---- stage 1: operand capture ----
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_opa_p1 <= '0;
        r_opb_p1 <= '0;
      end else if (w_ld[1]) begin
        r_opa_p1 <= din0;
        r_opb_p1 <= din1;
      end
    end

    assign w_mul = ext_a(r_opa_p1) * ext_b(r_opb_p1);

    if (NUM_STAGE == 2) begin : g_s2
      assign w_fin_src = w_mul;
    end else begin : g_s3
      logic signed [PW-1:0] r_prod_p [2:NUM_STAGE-1];

      // ---- stages 2..NUM_STAGE-1: product pipeline (retimable) ----
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int k = 2; k <= NUM_STAGE - 1; k++) r_prod_p[k] <= '0;
        end else begin
          if (w_ld[2]) r_prod_p[2] <= w_mul;
          for (int k = 3; k <= NUM_STAGE - 1; k++) begin
            if (w_ld[k]) r_prod_p[k] <= r_prod_p[k-1];
          end
        end
      end

      assign w_fin_src = r_prod_p[NUM_STAGE-1];
    end
  end

  // ---- final stage: wrap or clamp, then hold until the consumer takes it ----
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)              r_dout <= '0;
    else if (w_ld[NUM_STAGE])   r_dout <= fmt_result(w_fin_src);
  end

  assign in_ready  = w_adv[1];
  assign out_valid = r_vld[NUM_STAGE];
  assign dout      = r_dout;

endmodule
